ast_pkt_rr_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing one Avalon-ST sink (ast_width_extender input) among
//  N_SRC Avalon-ST sources. Grant is locked from sop to the eop handshake, so packets never interleave.

---
 rtl/ast_pkt_rr_arbiter_pkg.sv | 15 +
 rtl/ast_pkt_rr_arbiter_if.sv | 38 +++
 rtl/ast_pkt_rr_arbiter_rr_pick.sv | 49 ++++
 rtl/ast_pkt_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_ast_pkt_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ast_pkt_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-granular round-robin Avalon-ST arbiter.
// Arbiter FSM states and grant-index width calculation.
package ast_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of a source index; never below one bit so a degenerate N still yields a legal vector.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ast_pkt_rr_arbiter_if.sv
// Avalon-ST bundle of N_LANES parallel streams; lane k occupies slice k of every field.
// The master modport drives the payload and receives ready; the slave modport is the opposite side.
interface ast_pkt_rr_arbiter_if #(
  parameter int unsigned N_LANES   = 1,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned EMPTY_W   = 3,
  parameter int unsigned CHANNEL_W = 10
);

  logic [N_LANES*DATA_W-1:0]    data;
  logic [N_LANES-1:0]           startofpacket;
  logic [N_LANES-1:0]           endofpacket;
  logic [N_LANES-1:0]           valid;
  logic [N_LANES*EMPTY_W-1:0]   empty;
  logic [N_LANES*CHANNEL_W-1:0] channel;
  logic [N_LANES-1:0]           ready;

  modport master (
    output data,
    output startofpacket,
    output endofpacket,
    output valid,
    output empty,
    output channel,
    input  ready
  );

  modport slave (
    input  data,
    input  startofpacket,
    input  endofpacket,
    input  valid,
    input  empty,
    input  channel,
    output ready
  );

endinterface

// File: rtl/ast_pkt_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the slot after last_grant
// sits at bit 0, priority-encode the lowest set bit, then rotate the index back.
module rr_pick
  import ast_arb_pkg::*;
#(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned GRANT_W = grant_w(N_SRC)
) (
  input  logic [N_SRC-1:0]   req_i,
  input  logic [GRANT_W-1:0] last_grant_i,
  output logic [GRANT_W-1:0] winner_o,
  output logic               any_o
);

  logic [GRANT_W-1:0] start_idx;
  logic [2*N_SRC-1:0] req_dbl;
  logic [N_SRC-1:0]   req_rot;
  logic [GRANT_W-1:0] offset;
  logic               found;
  logic [GRANT_W:0]   idx_sum;

  always_comb begin
    start_idx = (last_grant_i == GRANT_W'(N_SRC - 1)) ? '0 : last_grant_i + GRANT_W'(1);
    req_dbl   = {req_i, req_i};
    req_rot   = req_dbl[start_idx +: N_SRC];
  end

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!found && req_rot[k]) begin
        offset = GRANT_W'(k);
        found  = 1'b1;
      end
    end
  end

  // Rotate back with an explicit wrap so non-power-of-two N_SRC stays in range.
  always_comb begin
    idx_sum = {1'b0, start_idx} + {1'b0, offset};
    if (idx_sum >= (GRANT_W + 1)'(N_SRC)) begin
      idx_sum = idx_sum - (GRANT_W + 1)'(N_SRC);
    end
    winner_o = idx_sum[GRANT_W-1:0];
    any_o    = |req_i;
  end

endmodule

// File: rtl/ast_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: N_SRC Avalon-ST sources share one sink, grant locked
// from sop to the eop handshake. Zero-latency data mux; only grant/state/counter are registered.
module ast_pkt_rr_arbiter
  import ast_arb_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned EMPTY_W   = 3,
  parameter int unsigned CHANNEL_W = 10,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        clk_i,
  input  logic                        srst_n_i,
  ast_pkt_rr_arbiter_if.slave         ast_src,
  ast_pkt_rr_arbiter_if.master        ast_snk,
  output logic [grant_w(N_SRC)-1:0]   grant_o,
  output logic                        busy_o,
  output logic [CNT_W-1:0]            drop_cnt_o
);

  localparam int unsigned GRANT_W = grant_w(N_SRC);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [N_SRC-1:0]   req;
  logic [N_SRC-1:0]   orphan;
  logic [N_SRC-1:0]   src_ready;
  logic [GRANT_W-1:0] winner;
  logic               any_req;
  logic [CNT_W:0]     orphan_cnt;
  logic [CNT_W:0]     drop_sum;

  logic [DATA_W-1:0]    sel_data;
  logic                 sel_sop;
  logic                 sel_eop;
  logic                 sel_valid;
  logic [EMPTY_W-1:0]   sel_empty;
  logic [CHANNEL_W-1:0] sel_channel;
  logic                 snk_valid;

  assign req    = ast_src.valid & ast_src.startofpacket;
  assign orphan = ast_src.valid & ~ast_src.startofpacket;

  rr_pick #(
    .N_SRC   (N_SRC),
    .GRANT_W (GRANT_W)
  ) u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .any_o        (any_req)
  );

  always_comb begin
    sel_data    = '0;
    sel_sop     = 1'b0;
    sel_eop     = 1'b0;
    sel_valid   = 1'b0;
    sel_empty   = '0;
    sel_channel = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (grant_q == GRANT_W'(k)) begin
        sel_data    = ast_src.data[k*DATA_W +: DATA_W];
        sel_sop     = ast_src.startofpacket[k];
        sel_eop     = ast_src.endofpacket[k];
        sel_valid   = ast_src.valid[k];
        sel_empty   = ast_src.empty[k*EMPTY_W +: EMPTY_W];
        sel_channel = ast_src.channel[k*CHANNEL_W +: CHANNEL_W];
      end
    end
  end

  // Several sources may orphan in the same cycle; add them all, then clamp at all-ones.
  always_comb begin
    orphan_cnt = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      orphan_cnt = orphan_cnt + (CNT_W + 1)'(orphan[k]);
    end
    drop_sum = {1'b0, drop_cnt_q} + orphan_cnt;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    drop_cnt_d   = drop_cnt_q;
    src_ready    = '0;
    snk_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        src_ready  = orphan;
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        if (any_req) begin
          grant_d      = winner;
          last_grant_d = winner;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        snk_valid = sel_valid;
        for (int unsigned k = 0; k < N_SRC; k++) begin
          if (grant_q == GRANT_W'(k)) begin
            src_ready[k] = ast_snk.ready;
          end
        end
        if (sel_valid && ast_snk.ready && sel_eop) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(N_SRC - 1);
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign ast_src.ready         = src_ready;
  assign ast_snk.data          = sel_data;
  assign ast_snk.startofpacket = sel_sop;
  assign ast_snk.endofpacket   = sel_eop;
  assign ast_snk.valid         = snk_valid;
  assign ast_snk.empty         = sel_empty;
  assign ast_snk.channel       = sel_channel;

  assign grant_o    = grant_q;
  assign busy_o     = (state_q == BUSY);
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_ast_pkt_rr_arbiter.sv
// Scoreboard bench for ast_pkt_rr_arbiter: directed packets feed per-source queues,
// expected sink beats go to a scoreboard that a negedge monitor pops on every sink handshake.
module tb_ast_pkt_rr_arbiter;

  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int EW   = 3;
  localparam int CW   = 10;
  localparam int CNTW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [CW-1:0] channel;
  } beat_t;

  typedef struct packed {
    beat_t      b;
    logic [1:0] g;
  } exp_t;

  logic            clk = 1'b0;
  logic            srst_n = 1'b0;
  logic [1:0]      grant;
  logic            busy;
  logic [CNTW-1:0] drop;

  always #5 clk = ~clk;

  ast_pkt_rr_arbiter_if #(.N_LANES(N), .DATA_W(DW), .EMPTY_W(EW), .CHANNEL_W(CW)) src_if ();
  ast_pkt_rr_arbiter_if #(.N_LANES(1), .DATA_W(DW), .EMPTY_W(EW), .CHANNEL_W(CW)) snk_if ();

  ast_pkt_rr_arbiter #(
    .N_SRC     (N),
    .DATA_W    (DW),
    .EMPTY_W   (EW),
    .CHANNEL_W (CW),
    .CNT_W     (CNTW)
  ) dut (
    .clk_i      (clk),
    .srst_n_i   (srst_n),
    .ast_src    (src_if),
    .ast_snk    (snk_if),
    .grant_o    (grant),
    .busy_o     (busy),
    .drop_cnt_o (drop)
  );

  beat_t src_q[N][$];
  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    last_eop = -1;
  bit    gap_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic beat_t mk(input int k, input int p, input int i, input int n, input bit sop_on);
    beat_t b;
    b.data    = 64'hA000_0000_0000_0000 | (64'(k) << 32) | (64'(p) << 16) | 64'(i);
    b.sop     = sop_on && (i == 0);
    b.eop     = (i == n - 1);
    b.empty   = (i == n - 1) ? 3'(k + 1) : 3'd0;
    b.channel = 10'(32'h100 + k);
    return b;
  endfunction

  // Queue an n-beat packet on source k; the first n_exp beats are expected at the sink with grant g.
  task automatic send_pkt(input int k, input int p, input int n, input int g, input int n_exp);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < n; i++) begin
      b = mk(k, p, i, n, 1'b1);
      src_q[k].push_back(b);
      if (i < n_exp) begin
        e.b = b;
        e.g = 2'(g);
        sb.push_back(e);
      end
    end
  endtask

  function automatic bit all_idle();
    bit r = (sb.size() == 0);
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string name, input int limit);
    int i = 0;
    while (!all_idle() && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (!all_idle()) begin
      checks++;
      errors++;
      $display("FAIL %s: drain timeout after %0d cycles, sb=%0d left", name, limit, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    repeat (2) @(negedge clk);
    srst_n = 1'b1;
    check("rst_valid", 128'(snk_if.valid), 128'(0));
    check("rst_ready", 128'(src_if.ready), 128'(0));
    check("rst_busy",  128'(busy), 128'(0));
    check("rst_grant", 128'(grant), 128'(0));
    check("rst_drop",  128'(drop), 128'(0));
  endtask

  // Source driver: retire handshaken beats, then present each queue head.
  initial begin
    logic [N-1:0] fire;
    src_if.data          = '0;
    src_if.startofpacket = '0;
    src_if.endofpacket   = '0;
    src_if.valid         = '0;
    src_if.empty         = '0;
    src_if.channel       = '0;
    forever begin
      @(negedge clk);
      fire = src_if.valid & src_if.ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          src_if.data[k*DW +: DW]    = src_q[k][0].data;
          src_if.startofpacket[k]    = src_q[k][0].sop;
          src_if.endofpacket[k]      = src_q[k][0].eop;
          src_if.empty[k*EW +: EW]   = src_q[k][0].empty;
          src_if.channel[k*CW +: CW] = src_q[k][0].channel;
          src_if.valid[k]            = 1'b1;
        end else begin
          src_if.valid[k] = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every sink handshake against the scoreboard head.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      if (snk_if.valid && snk_if.ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h with empty scoreboard", snk_if.data);
        end else begin
          e = sb.pop_front();
          act.b.data    = snk_if.data;
          act.b.sop     = snk_if.startofpacket;
          act.b.eop     = snk_if.endofpacket;
          act.b.empty   = snk_if.empty;
          act.b.channel = snk_if.channel;
          act.g         = grant;
          check("beat", 128'(act), 128'(e));
          check("ready_mirror", 128'(src_if.ready), 128'(4'b0001 << e.g));
          if (act.b.sop && gap_en && last_eop >= 0) check("eop_to_sop_gap", 128'(cyc - last_eop), 128'(2));
          if (act.b.eop) last_eop = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    snk_if.ready = 1'b1;
    @(negedge clk);
    do_reset();

    // 1: single 16-beat packet from source 0
    send_pkt(0, 0, 16, 0, 16);
    @(negedge clk);
    check("t1_bubble_valid", 128'(snk_if.valid), 128'(0));
    check("t1_bubble_ready", 128'(src_if.ready), 128'(0));
    @(negedge clk);
    check("t1_sop_out", 128'({snk_if.valid, snk_if.startofpacket, grant}), 128'({1'b1, 1'b1, 2'd0}));
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("t1_contiguous", 128'(snk_if.valid), 128'(1));
    end
    drain("t1", 100);

    // 2: all sources request at once, fresh priority
    do_reset();
    last_eop = -1;
    gap_en = 1'b1;
    send_pkt(0, 0, 3, 0, 3);
    send_pkt(1, 0, 3, 1, 3);
    send_pkt(2, 0, 3, 2, 3);
    send_pkt(3, 0, 3, 3, 3);
    send_pkt(0, 1, 3, 0, 3);
    drain("t2", 100);
    gap_en = 1'b0;

    // 3: source 1 raises sop while source 2 is mid-packet
    send_pkt(2, 1, 4, 2, 4);
    repeat (2) @(negedge clk);
    send_pkt(1, 1, 2, 1, 2);
    for (int i = 0; i < 20 && src_q[2].size() > 0; i++) begin
      @(negedge clk);
      check("t3_src1_blocked", 128'(src_if.ready[1]), 128'(0));
    end
    drain("t3", 100);

    // 4: sink ready 2 on / 2 off during a 5-beat packet
    send_pkt(0, 2, 5, 0, 5);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      snk_if.ready = ((i / 2) % 2 == 0);
      @(negedge clk);
      check("t4_others_ready", 128'(src_if.ready & 4'b1110), 128'(0));
      if (snk_if.valid) check("t4_ready_mirror", 128'(src_if.ready[0]), 128'(snk_if.ready));
    end
    snk_if.ready = 1'b1;
    drain("t4", 100);

    // 5: orphan beats from source 3 while idle
    for (int i = 0; i < 3; i++) src_q[3].push_back(mk(3, 9, i, 100, 1'b0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_valid", 128'(snk_if.valid), 128'(0));
    end
    drain("t5", 50);
    check("t5_drop_cnt", 128'(drop), 128'(3));

    // 6: reset during beat 2 of a 4-beat packet from source 1
    send_pkt(1, 2, 4, 1, 2);
    repeat (3) @(negedge clk);
    srst_n = 1'b0;
    @(negedge clk);
    srst_n = 1'b1;
    check("t6_after_rst_busy", 128'(busy), 128'(0));
    check("t6_after_rst_valid", 128'(snk_if.valid), 128'(0));
    drain("t6a", 50);
    check("t6_drop_cnt", 128'(drop), 128'(2));
    send_pkt(0, 3, 2, 0, 2);
    send_pkt(2, 3, 2, 2, 2);
    drain("t6b", 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
